// File: rtl/nvdla_tcdm_responder.sv
// rtl/nvdla_tcdm_responder.sv - TCDM slave memory model with throttled grant and fixed read latency
module nvdla_tcdm_responder #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned MEM_WORDS  = 256,
   parameter int unsigned LATENCY    = 1,
   parameter int unsigned GNT_PERIOD = 0
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    clear_i,
   input  logic                    stall_i,
   input  logic                    tcdm_req_i,
   output logic                    tcdm_gnt_o,
   input  logic [ADDR_WIDTH-1:0]   tcdm_add_i,
   input  logic                    tcdm_wen_i,
   input  logic [DATA_WIDTH/8-1:0] tcdm_be_i,
   input  logic [DATA_WIDTH-1:0]   tcdm_data_i,
   output logic [DATA_WIDTH-1:0]   tcdm_r_data_o,
   output logic                    tcdm_r_valid_o,
   output logic [31:0]             n_reads_o,
   output logic [31:0]             n_writes_o
);

   localparam int unsigned NB  = DATA_WIDTH / 8;
   localparam int unsigned OFF = $clog2(NB);
   localparam int unsigned IW  = $clog2(MEM_WORDS);
   localparam int unsigned TW  = (GNT_PERIOD > 0) ? $clog2(GNT_PERIOD + 1) : 1;

   logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
   logic [IW-1:0]         idx;
   logic [TW-1:0]         thr_cnt;
   logic                  xfer;
   logic                  rd_xfer;
   logic                  wr_xfer;
   logic [LATENCY-1:0]    vld;
   logic [DATA_WIDTH-1:0] pdata [LATENCY];
   logic                  unused_add;

   // Upper address bits wrap onto the array; byte-offset bits are ignored.
   assign idx        = tcdm_add_i[OFF +: IW];
   assign unused_add = ^tcdm_add_i;

   assign tcdm_gnt_o = tcdm_req_i & ~stall_i & (thr_cnt == '0) & ~clear_i;
   assign xfer       = tcdm_req_i & tcdm_gnt_o;
   assign rd_xfer    = xfer & tcdm_wen_i;
   assign wr_xfer    = xfer & ~tcdm_wen_i;

   always_ff @(posedge clk_i) begin
      if (wr_xfer) begin
         for (int b = 0; b < NB; b++) begin
            if (tcdm_be_i[b]) mem[idx][b*8 +: 8] <= tcdm_data_i[b*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vld        <= '0;
         thr_cnt    <= '0;
         n_reads_o  <= '0;
         n_writes_o <= '0;
      end else if (clear_i) begin
         vld        <= '0;
         thr_cnt    <= '0;
         n_reads_o  <= '0;
         n_writes_o <= '0;
      end else begin
         vld[0] <= rd_xfer;
         for (int s = 1; s < LATENCY; s++) vld[s] <= vld[s-1];
         if (xfer)                thr_cnt <= TW'(GNT_PERIOD);
         else if (thr_cnt != '0)  thr_cnt <= thr_cnt - 1'b1;
         if (rd_xfer) n_reads_o  <= n_reads_o + 32'd1;
         if (wr_xfer) n_writes_o <= n_writes_o + 32'd1;
      end
   end

   // Data stages carry no meaning without their valid bit, so clear leaves them alone.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int s = 0; s < LATENCY; s++) pdata[s] <= '0;
      end else begin
         if (rd_xfer) pdata[0] <= mem[idx];
         for (int s = 1; s < LATENCY; s++) pdata[s] <= pdata[s-1];
      end
   end

   assign tcdm_r_valid_o = vld[LATENCY-1];
   assign tcdm_r_data_o  = vld[LATENCY-1] ? pdata[LATENCY-1] : '0;

endmodule

// File: tb/tb_nvdla_tcdm_responder.sv
// tb/tb_nvdla_tcdm_responder.sv - directed vector bench for nvdla_tcdm_responder
module tb_nvdla_tcdm_responder;

   logic        clk;
   logic        rst_n;
   logic        req   [3];
   logic        wen   [3];
   logic        stall [3];
   logic        clr   [3];
   logic [31:0] add   [3];
   logic [3:0]  be    [3];
   logic [31:0] wdata [3];
   logic        gnt   [3];
   logic        rv    [3];
   logic [31:0] rdata [3];
   logic [31:0] nr    [3];
   logic [31:0] nw    [3];

   // Instance 0: LATENCY 1, no throttle; 1: LATENCY 1, GNT_PERIOD 2; 2: LATENCY 3, no throttle.
   for (genvar g = 0; g < 3; g++) begin : g_dut
      nvdla_tcdm_responder #(
         .DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_WORDS(256),
         .LATENCY((g == 2) ? 3 : 1), .GNT_PERIOD((g == 1) ? 2 : 0)
      ) u_dut (
         .clk_i(clk), .rst_ni(rst_n), .clear_i(clr[g]), .stall_i(stall[g]),
         .tcdm_req_i(req[g]), .tcdm_gnt_o(gnt[g]), .tcdm_add_i(add[g]),
         .tcdm_wen_i(wen[g]), .tcdm_be_i(be[g]), .tcdm_data_i(wdata[g]),
         .tcdm_r_data_o(rdata[g]), .tcdm_r_valid_o(rv[g]),
         .n_reads_o(nr[g]), .n_writes_o(nw[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          d;
      logic        req, wen, stall;
      logic [31:0] add;
      logic [3:0]  be;
      logic [31:0] data;
      logic        gnt, rv;
      logic [31:0] rd;
   } vec_t;

   vec_t tv[$];
   int   n_cmp = 0;
   int   n_err = 0;

   function automatic void v(int d, logic r, logic w, logic s, logic [31:0] a, logic [3:0] b,
                             logic [31:0] dt, logic g, logic val, logic [31:0] rd);
      vec_t e;
      e.d = d; e.req = r; e.wen = w; e.stall = s; e.add = a; e.be = b; e.data = dt;
      e.gnt = g; e.rv = val; e.rd = rd;
      tv.push_back(e);
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic idle_all();
      for (int k = 0; k < 3; k++) begin
         req[k] = 1'b0; wen[k] = 1'b0; stall[k] = 1'b0; clr[k] = 1'b0;
         add[k] = '0; be[k] = '0; wdata[k] = '0;
      end
   endtask

   task automatic drive(int d, logic r, logic w, logic [31:0] a);
      idle_all();
      req[d] = r; wen[d] = w; add[d] = a;
   endtask

   initial begin
      rst_n = 1'b0;
      idle_all();

      // instance 0: write/read, byte enables, wrap, stall
      v(0, 1, 0, 0, 32'h10,  4'hF, 32'hDEADBEEF, 1, 0, 0);
      v(0, 1, 1, 0, 32'h10,  4'h0, 0,            1, 0, 0);
      v(0, 0, 0, 0, 0,       4'h0, 0,            0, 1, 32'hDEADBEEF);
      v(0, 1, 0, 0, 32'h20,  4'hF, 32'h11223344, 1, 0, 0);
      v(0, 1, 0, 0, 32'h20,  4'h5, 32'hAABBCCDD, 1, 0, 0);
      v(0, 1, 1, 0, 32'h20,  4'h0, 0,            1, 0, 0);
      v(0, 0, 0, 0, 0,       4'h0, 0,            0, 1, 32'h11BB33DD);
      v(0, 1, 0, 0, 32'h400, 4'hF, 32'h5,        1, 0, 0);
      v(0, 1, 1, 0, 32'h0,   4'h0, 0,            1, 0, 0);
      v(0, 0, 0, 0, 0,       4'h0, 0,            0, 1, 32'h5);
      for (int i = 0; i < 4; i++) v(0, 1, 1, 1, 32'h10, 4'h0, 0, 0, 0, 0);
      v(0, 1, 1, 0, 32'h10,  4'h0, 0,            1, 0, 0);
      v(0, 0, 0, 0, 0,       4'h0, 0,            0, 1, 32'hDEADBEEF);
      // instance 1: throttle with GNT_PERIOD=2
      v(1, 1, 0, 0, 32'h8,   4'hF, 32'hCAFE0001, 1, 0, 0);
      v(1, 0, 0, 0, 0,       4'h0, 0,            0, 0, 0);
      v(1, 0, 0, 0, 0,       4'h0, 0,            0, 0, 0);
      for (int c = 0; c < 9; c++)
         v(1, 1, 1, 0, 32'h8, 4'h0, 0, (c % 3) == 0, (c % 3) == 1, ((c % 3) == 1) ? 32'hCAFE0001 : 0);
      v(1, 0, 0, 0, 0,       4'h0, 0,            0, 0, 0);
      // instance 2: LATENCY=3 streaming
      for (int i = 0; i < 4; i++) v(2, 1, 0, 0, 4 * i, 4'hF, 32'hA0 + i, 1, 0, 0);
      for (int i = 0; i < 4; i++) v(2, 1, 1, 0, 4 * i, 4'h0, 0, 1, i == 3, (i == 3) ? 32'hA0 : 0);
      for (int i = 1; i < 4; i++) v(2, 0, 0, 0, 0, 4'h0, 0, 0, 1, 32'hA0 + i);
      v(2, 0, 0, 0, 0,       4'h0, 0,            0, 0, 0);

      @(negedge clk); #1;
      chk("reset r_valid", {31'd0, rv[0]}, 0);
      chk("reset r_data", rdata[0], 0);
      chk("reset n_reads", nr[0], 0);
      chk("reset n_writes", nw[0], 0);
      rst_n = 1'b1;

      foreach (tv[i]) begin
         @(negedge clk);
         idle_all();
         req[tv[i].d] = tv[i].req; wen[tv[i].d] = tv[i].wen; stall[tv[i].d] = tv[i].stall;
         add[tv[i].d] = tv[i].add; be[tv[i].d] = tv[i].be; wdata[tv[i].d] = tv[i].data;
         #1;
         chk($sformatf("row%0d gnt", i), {31'd0, gnt[tv[i].d]}, {31'd0, tv[i].gnt});
         chk($sformatf("row%0d r_valid", i), {31'd0, rv[tv[i].d]}, {31'd0, tv[i].rv});
         chk($sformatf("row%0d r_data", i), rdata[tv[i].d], tv[i].rd);
      end

      chk("d0 n_reads", nr[0], 4);
      chk("d0 n_writes", nw[0], 4);
      chk("d1 n_reads", nr[1], 3);
      chk("d1 n_writes", nw[1], 1);
      chk("d2 n_reads", nr[2], 4);
      chk("d2 n_writes", nw[2], 4);

      // clear one cycle after a read grant drops it and zeroes counters
      @(negedge clk); drive(2, 1, 1, 32'h0); #1;
      chk("clr read gnt", {31'd0, gnt[2]}, 1);
      @(negedge clk); drive(2, 1, 1, 32'h0); clr[2] = 1'b1; #1;
      chk("clr cycle gnt", {31'd0, gnt[2]}, 0);
      chk("pre-clr n_reads", nr[2], 5);
      @(negedge clk); idle_all(); #1;
      chk("post-clr n_reads", nr[2], 0);
      chk("post-clr n_writes", nw[2], 0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #1;
         chk($sformatf("post-clr r_valid%0d", i), {31'd0, rv[2]}, 0);
      end

      // async reset while one read is presenting and another is in flight
      @(negedge clk); drive(2, 1, 1, 32'h0);
      @(negedge clk); drive(2, 1, 1, 32'h4);
      @(negedge clk); idle_all();
      @(negedge clk); #1;
      chk("pre-rst r_valid", {31'd0, rv[2]}, 1);
      chk("pre-rst r_data", rdata[2], 32'hA0);
      rst_n = 1'b0; #1;
      chk("async rst r_valid", {31'd0, rv[2]}, 0);
      chk("async rst r_data", rdata[2], 0);
      chk("async rst n_reads", nr[2], 0);
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         chk($sformatf("post-rst r_valid%0d", i), {31'd0, rv[2]}, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
